// File: rtl/osf_channel_filter.sv
// osf_channel_filter: one ADC channel's settling-delay gate followed by a
// 2^osm boxcar average that emits one decimated sample per block.
// Filter parameters are staged on the inputs and only take effect on a
// global update strobe when this channel's update enable is set.
module osf_channel_filter #(
   parameter int W_DIN   = 18,
   parameter int W_CD    = 16,
   parameter int W_OSM   = 6,
   parameter int OSM_MAX = 10
) (
   input  logic                    clk_in,
   input  logic                    reset_in,
   input  logic                    data_valid_in,
   input  logic signed [W_DIN-1:0] data_in,
   input  logic                    activate_in,
   input  logic [W_CD-1:0]         cycle_delay_in,
   input  logic [W_OSM-1:0]        osm_in,
   input  logic                    update_en_in,
   input  logic                    module_update_in,
   output logic                    data_valid_out,
   output logic signed [W_DIN-1:0] data_out
);

   // Accumulator is wide enough for 2^OSM_MAX full-scale samples, so it never wraps.
   localparam int W_ACC = W_DIN + OSM_MAX;
   localparam int W_CNT = OSM_MAX + 1;

   typedef enum logic [1:0] {IDLE, DELAY, ACCUM, DUMP} state_t;

   state_t                  state;
   state_t                  state_next;

   logic [W_CD-1:0]         cycle_delay;
   logic [W_OSM-1:0]        osm;
   logic [W_CD-1:0]         delay_cnt;
   logic [W_CNT-1:0]        sample_cnt;
   logic signed [W_ACC-1:0] acc;

   logic                    commit;
   logic                    clear;
   logic                    delay_inc;
   logic                    add_sample;
   logic                    dump;
   logic [W_OSM-1:0]        osm_clamped;
   logic [W_CNT-1:0]        sample_target;
   logic signed [W_DIN-1:0] average;

   assign commit        = module_update_in & update_en_in;
   assign osm_clamped   = (osm_in > W_OSM'(OSM_MAX)) ? W_OSM'(OSM_MAX) : osm_in;
   assign sample_target = W_CNT'(1) << osm;
   // Arithmetic shift floors toward minus infinity for negative sums.
   assign average       = W_DIN'(acc >>> osm);

   // State register.
   always_ff @(posedge clk_in or posedge reset_in) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset_in) state <= IDLE;
      else          state <= state_next;
   end

   // Next state and datapath control: commit beats deactivation beats normal flow.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_next = state;
      clear      = 1'b0;
      delay_inc  = 1'b0;
      add_sample = 1'b0;
      dump       = 1'b0;
      if (commit) begin
         // The sample arriving with the commit is dropped along with the partial sum.
         clear      = 1'b1;
         state_next = activate_in ? DELAY : IDLE;
      end else if (!activate_in) begin
         // Leaving mid-block discards the partial sum; no output is produced.
         clear      = 1'b1;
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               clear      = 1'b1;
               state_next = DELAY;
            end
            DELAY: begin
               // Counts clock cycles, not samples; a zero delay still spends one cycle here.
               if (cycle_delay == '0 || delay_cnt == cycle_delay - W_CD'(1)) begin
                  clear      = 1'b1;
                  state_next = ACCUM;
               end else begin
                  delay_inc = 1'b1;
               end
            end
            ACCUM: begin
               if (data_valid_in) begin
                  add_sample = 1'b1;
                  if (sample_cnt + W_CNT'(1) == sample_target) state_next = DUMP;
               end
            end
            DUMP: begin
               dump       = 1'b1;
               clear      = 1'b1;
               state_next = DELAY;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Committed parameters, accumulator, counters and registered output.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         cycle_delay    <= '0;
         osm            <= '0;
         delay_cnt      <= '0;
         sample_cnt     <= '0;
         acc            <= '0;
         data_valid_out <= 1'b0;
         data_out       <= '0;
      end else begin
         if (commit) begin
            cycle_delay <= cycle_delay_in;
            osm         <= osm_clamped;
         end
         if (clear) begin
            acc        <= '0;
            sample_cnt <= '0;
            delay_cnt  <= '0;
         end else begin
            if (add_sample) begin
               acc        <= acc + W_ACC'(data_in);
               sample_cnt <= sample_cnt + W_CNT'(1);
            end
            if (delay_inc) delay_cnt <= delay_cnt + W_CD'(1);
         end
         // DUMP reads the accumulator before the same-edge clear takes effect.
         data_valid_out <= dump;
         if (dump) data_out <= average;
      end
   end

endmodule

// File: tb/tb_osf_channel_filter.sv
// Directed bench for osf_channel_filter: inputs change 1 ns after each rising
// edge and outputs are sampled at that same point, so each check sees the
// result of the edge just taken.
module tb_osf_channel_filter;

   logic               clk_in;
   logic               reset_in;
   logic               data_valid_in;
   logic signed [17:0] data_in;
   logic               activate_in;
   logic [15:0]        cycle_delay_in;
   logic [5:0]         osm_in;
   logic               update_en_in;
   logic               module_update_in;
   logic               data_valid_out;
   logic signed [17:0] data_out;

   int total = 0;
   int bad   = 0;
   int pulses = 0;

   osf_channel_filter dut (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .data_valid_in    (data_valid_in),
      .data_in          (data_in),
      .activate_in      (activate_in),
      .cycle_delay_in   (cycle_delay_in),
      .osm_in           (osm_in),
      .update_en_in     (update_en_in),
      .module_update_in (module_update_in),
      .data_valid_out   (data_valid_out),
      .data_out         (data_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Count every output pulse so stray pulses show up in the totals.
   always @(negedge clk_in) if (data_valid_out === 1'b1) pulses++;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic feed(input logic signed [17:0] v);
      data_valid_in = 1'b1;
      data_in       = v;
      tick();
      data_valid_in = 1'b0;
   endtask

   task automatic commit(input logic [15:0] cd, input logic [5:0] om);
      update_en_in     = 1'b1;
      module_update_in = 1'b1;
      cycle_delay_in   = cd;
      osm_in           = om;
      tick();
      module_update_in = 1'b0;
      data_valid_in    = 1'b0;
   endtask

   initial begin
      int p_mark;
      reset_in         = 1'b1;
      data_valid_in    = 1'b0;
      data_in          = '0;
      activate_in      = 1'b0;
      cycle_delay_in   = '0;
      osm_in           = '0;
      update_en_in     = 1'b0;
      module_update_in = 1'b0;
      tick();
      tick();
      check("reset_valid", data_valid_out, 0);
      check("reset_data", data_out, 0);
      reset_in = 1'b0;

      // 1: cd=0 osm=2, samples 4,8,12,16 -> 10, pulse on 2nd edge after the last sample
      activate_in = 1'b1;
      commit(16'd0, 6'd2);
      tick();
      feed(4); feed(8); feed(12); feed(16);
      check("t1_no_early_pulse", data_valid_out, 0);
      tick();
      check("t1_valid", data_valid_out, 1);
      check("t1_data", data_out, 10);
      tick();
      check("t1_pulse_one_cycle", data_valid_out, 0);
      check("t1_data_hold", data_out, 10);

      // 2: cd=5 osm=0, valid every cycle; 6 samples dropped, then one out per 7 cycles
      for (int k = 0; k < 16; k++) begin
         module_update_in = (k == 0);
         update_en_in     = 1'b1;
         cycle_delay_in   = 16'd5;
         osm_in           = 6'd0;
         data_valid_in    = 1'b1;
         data_in          = 18'(100 + k);
         tick();
         check($sformatf("t2_valid_k%0d", k), data_valid_out, (k == 7 || k == 14) ? 1 : 0);
         if (k == 7 || k == 14) check($sformatf("t2_data_k%0d", k), data_out, 100 + k - 1);
      end
      module_update_in = 1'b0;
      data_valid_in    = 1'b0;

      // 3: negative average floors; full-scale positive does not wrap
      commit(16'd0, 6'd2);
      tick();
      feed(-3); feed(-3); feed(-3); feed(-2);
      check("t3_neg_no_early", data_valid_out, 0);
      tick();
      check("t3_neg_valid", data_valid_out, 1);
      check("t3_neg_data", data_out, -3);
      tick();
      for (int i = 0; i < 4; i++) feed(131071);
      tick();
      check("t3_max_valid", data_valid_out, 1);
      check("t3_max_data", data_out, 131071);

      // 4: osm=63 clamps to 10 -> exactly 1024 samples per output
      commit(16'd0, 6'd63);
      tick();
      p_mark = pulses;
      for (int i = 0; i < 1023; i++) feed(7);
      check("t4_no_pulse_before_1024", pulses, p_mark);
      check("t4_valid_before_1024", data_valid_out, 0);
      feed(7);
      tick();
      check("t4_valid", data_valid_out, 1);
      check("t4_data", data_out, 7);

      // 5: sample on commit edge dropped; strobe without enable changes nothing
      data_valid_in = 1'b1;
      data_in       = 18'sd1000;
      commit(16'd0, 6'd2);
      tick();
      feed(4); feed(4);
      update_en_in     = 1'b0;
      module_update_in = 1'b1;
      cycle_delay_in   = 16'd9;
      osm_in           = 6'd0;
      feed(8);
      module_update_in = 1'b0;
      check("t5_no_pulse_after_gated", data_valid_out, 0);
      update_en_in = 1'b1;
      feed(8);
      check("t5_no_early", data_valid_out, 0);
      tick();
      check("t5_valid", data_valid_out, 1);
      check("t5_data", data_out, 6);
      tick();
      feed(2); feed(2); feed(2); feed(2);
      tick();
      check("t5_params_kept_valid", data_valid_out, 1);
      check("t5_params_kept_data", data_out, 2);

      // 6: deactivate after 2 of 4 samples; next block averages only new samples
      tick();
      p_mark = pulses;
      feed(100); feed(100);
      activate_in = 1'b0;
      feed(100);
      feed(100);
      tick();
      check("t6_idle_no_pulse", pulses, p_mark);
      check("t6_data_kept", data_out, 2);
      activate_in = 1'b1;
      tick();
      tick();
      feed(20); feed(20); feed(20); feed(24);
      tick();
      check("t6_valid", data_valid_out, 1);
      check("t6_data", data_out, 21);

      // 7: async reset mid-ACCUM clears outputs without a clock edge
      tick();
      feed(5); feed(5);
      #2 reset_in = 1'b1;
      #1;
      check("t7_reset_data", data_out, 0);
      check("t7_reset_valid", data_valid_out, 0);
      tick();
      reset_in = 1'b0;
      tick();
      tick();
      feed(-9);
      tick();
      check("t7_post_reset_valid", data_valid_out, 1);
      check("t7_post_reset_data", data_out, -9);
      tick();
      check("t7_post_reset_single", data_valid_out, 0);

      check("total_pulses", pulses, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
